// File: rtl/kernel_array_sequencer_pkg.sv
// kernel_seq_pkg: shared types and default widths for the kernel array sequencer.
//   seq_state_e : sequencer states IDLE, START, RUN, DONE
//   owner_e     : which side drives the array port (HOST or KERNEL)
//   ADDR_W_DEF / DATA_W_DEF : default array address / data widths
package kernel_seq_pkg;
   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 64;
   typedef enum logic [1:0] {IDLE, START, RUN, DONE} seq_state_e;
   typedef enum logic {HOST, KERNEL} owner_e;
endpackage

// File: rtl/kernel_array_sequencer_mux.sv
// array_port_mux: combinational selection of the RAM port from host or kernel.
//   owner                              : selected side
//   host_req/host_we/host_addr/host_wdata : host access
//   kern_we/kern_addr/kern_wdata       : kernel access
//   mem_we/mem_addr/mem_wdata          : RAM port; mem_we is 0 unless the selected side writes
module array_port_mux
   import kernel_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  owner_e              owner,
   input  logic                host_req,
   input  logic                host_we,
   input  logic [ADDR_W-1:0]   host_addr,
   input  logic [DATA_W-1:0]   host_wdata,
   input  logic                kern_we,
   input  logic [ADDR_W-1:0]   kern_addr,
   input  logic [DATA_W-1:0]   kern_wdata,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata
);
   always_comb begin
      mem_we    = owner == KERNEL ? kern_we : host_req & host_we;
      mem_addr  = owner == KERNEL ? kern_addr : host_addr;
      mem_wdata = owner == KERNEL ? kern_wdata : host_wdata;
   end
endmodule

// File: rtl/kernel_array_sequencer.sv
// kernel_array_sequencer: hands a single-port array RAM between host and one kernel.
//   clk, rst                 : clock, synchronous active-high reset
//   host_req/we/addr/wdata   : host access; host_gnt accepts it (combinational)
//   host_rvalid/host_rdata   : read data, one cycle after a granted read
//   run / busy / done        : kernel start request, kernel owns array, completion pulse
//   kern_r_enable/w_enable   : kernel start pulse / kernel finished
//   kern_we/addr/wdata/rdata : kernel array port
//   mem_we/addr/wdata/rdata  : RAM port (registered read, 1-cycle latency)
//   run_cycles               : START+RUN cycle count, only with KERNEL_CYCLE_COUNT_EN
module kernel_array_sequencer
   import kernel_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                host_req,
   input  logic                host_we,
   input  logic [ADDR_W-1:0]   host_addr,
   input  logic [DATA_W-1:0]   host_wdata,
   output logic                host_gnt,
   output logic                host_rvalid,
   output logic [DATA_W-1:0]   host_rdata,
   input  logic                run,
   output logic                busy,
   output logic                done,
   output logic                kern_r_enable,
   input  logic                kern_w_enable,
   input  logic                kern_we,
   input  logic [ADDR_W-1:0]   kern_addr,
   input  logic [DATA_W-1:0]   kern_wdata,
   output logic [DATA_W-1:0]   kern_rdata,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
`ifdef KERNEL_CYCLE_COUNT_EN
   output logic [31:0]         run_cycles,
`endif
   input  logic [DATA_W-1:0]   mem_rdata
);
   seq_state_e state, state_n;
   owner_e     owner;
   always_comb begin
      state_n  = state == IDLE  ? (run ? START : IDLE)
               : state == START ? RUN
               : state == RUN   ? (kern_w_enable ? DONE : RUN)
               : IDLE;
      owner    = (state == START || state == RUN) ? KERNEL : HOST;
      host_gnt = host_req && owner == HOST;
   end
   // Status outputs are registered from the next state so they line up with state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         kern_r_enable <= 1'b0;
         host_rvalid   <= 1'b0;
      end else begin
         state         <= state_n;
         busy          <= state_n == START || state_n == RUN;
         done          <= state_n == DONE;
         kern_r_enable <= state_n == START;
         host_rvalid   <= host_gnt & ~host_we;
      end
   end
`ifdef KERNEL_CYCLE_COUNT_EN
   // Cleared on the edge into START, so START itself is the first counted cycle.
   always_ff @(posedge clk) begin
      if (rst)
         run_cycles <= '0;
      else if (state == IDLE && state_n == START)
         run_cycles <= '0;
      else if (state == START || state == RUN)
         run_cycles <= run_cycles + {31'd0, ~&run_cycles};
   end
`endif
   assign host_rdata = mem_rdata;
   assign kern_rdata = mem_rdata;
   array_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
      .owner      (owner),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .kern_we    (kern_we),
      .kern_addr  (kern_addr),
      .kern_wdata (kern_wdata),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata)
   );
endmodule

// File: tb/tb_kernel_array_sequencer.sv
// tb_kernel_array_sequencer: directed and randomized checks of the kernel array sequencer.
module tb_kernel_array_sequencer;
   logic        clk = 0, rst = 0;
   logic        host_req = 0, host_we = 0;
   logic [9:0]  host_addr = 0;
   logic [63:0] host_wdata = 0;
   logic        host_gnt, host_rvalid;
   logic [63:0] host_rdata;
   logic        run = 0, busy, done, kern_r_enable;
   logic        kern_w_enable = 0, kern_we = 0;
   logic [9:0]  kern_addr = 0;
   logic [63:0] kern_wdata = 0, kern_rdata;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [63:0] mem_wdata, mem_rdata;
`ifdef KERNEL_CYCLE_COUNT_EN
   logic [31:0] run_cycles;
`endif
   logic [63:0] ram [0:1023];
   logic [63:0] exp_mem [0:1023];
   int          vectors = 0, miscompares = 0;
   logic        prev_hrd = 0;
   logic [9:0]  prev_ha = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   kernel_array_sequencer #(.ADDR_W(10), .DATA_W(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .host_req      (host_req),
      .host_we       (host_we),
      .host_addr     (host_addr),
      .host_wdata    (host_wdata),
      .host_gnt      (host_gnt),
      .host_rvalid   (host_rvalid),
      .host_rdata    (host_rdata),
      .run           (run),
      .busy          (busy),
      .done          (done),
      .kern_r_enable (kern_r_enable),
      .kern_w_enable (kern_w_enable),
      .kern_we       (kern_we),
      .kern_addr     (kern_addr),
      .kern_wdata    (kern_wdata),
      .kern_rdata    (kern_rdata),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
`ifdef KERNEL_CYCLE_COUNT_EN
      .run_cycles    (run_cycles),
`endif
      .mem_rdata     (mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic host_random(input int n);
      prev_hrd = 0;
      for (int i = 0; i < n; i++) begin
         host_req   = 1'($urandom_range(0, 1));
         host_we    = 1'($urandom_range(0, 1));
         host_addr  = 10'($urandom_range(0, 999));
         host_wdata = {$urandom, $urandom};
         #1;
         chk("rnd_gnt", host_gnt, host_req);
         chk("rnd_mem_we", mem_we, host_req & host_we);
         chk("rnd_rvalid", host_rvalid, prev_hrd);
         if (prev_hrd) chk("rnd_rdata", host_rdata, exp_mem[prev_ha]);
         if (host_req && host_we) exp_mem[host_addr] = host_wdata;
         prev_hrd = host_req & ~host_we;
         prev_ha  = host_addr;
         tick;
      end
      host_req = 0;
   endtask

   // One kernel job: START, then lat RUN cycles (kern_w_enable in the last one), DONE, IDLE.
   // abort_at > 0 asserts rst during that RUN cycle instead of finishing.
   task automatic run_kernel(input int lat, input bit rd3, input int abort_at);
      int          busy_n = 0, kre_n = 0, done_n = 0;
      logic        kw, prev_krd = 0;
      logic [9:0]  ka, prev_ka = 0;
      logic [63:0] kd;
      run = 1; host_req = rd3; host_we = 0; host_addr = 3;
      kern_w_enable = 0; kern_we = 0;
      #1;
      chk("run_cycle_gnt", host_gnt, rd3);
      chk("run_cycle_busy", busy, 0);
      tick;
      for (int c = 0; c <= lat; c++) begin
         rst        = abort_at != 0 && c == abort_at;
         run        = 1'($urandom_range(0, 1));
         host_req   = 1'($urandom_range(0, 1));
         host_we    = 1'($urandom_range(0, 1));
         host_addr  = 10'($urandom_range(0, 999));
         host_wdata = {$urandom, $urandom};
         kern_w_enable = c == 0 || c == lat;
         kw = 1'($urandom_range(0, 1));
         ka = 10'($urandom_range(0, 999));
         kd = {$urandom, $urandom};
         if (c == lat) begin kw = 1; ka = 12; kd = 64'hFFFF_FFFF_FFFF_FFFC; end
         kern_we = kw; kern_addr = ka; kern_wdata = kd;
         #1;
         chk("k_busy", busy, 1);
         chk("k_r_enable", kern_r_enable, c == 0);
         chk("k_done", done, 0);
         chk("k_host_gnt", host_gnt, 0);
         chk("k_mem_we", mem_we, kw);
         chk("k_mem_addr", mem_addr, ka);
         if (kw) chk("k_mem_wdata", mem_wdata, kd);
         chk("k_rvalid", host_rvalid, c == 0 && rd3);
         if (c == 0 && rd3) chk("start_rdata3", host_rdata, exp_mem[3]);
         if (prev_krd) chk("k_rdata", kern_rdata, exp_mem[prev_ka]);
`ifdef KERNEL_CYCLE_COUNT_EN
         chk("k_run_cycles", run_cycles, c);
`endif
         busy_n += int'(busy); kre_n += int'(kern_r_enable); done_n += int'(done);
         if (kw) exp_mem[ka] = kd;
         prev_krd = ~kw; prev_ka = ka;
         tick;
         if (rst) begin
            rst = 0; run = 0; host_req = 0; kern_w_enable = 0; kern_we = 0;
            #1;
            chk("abort_busy", busy, 0);
            chk("abort_r_enable", kern_r_enable, 0);
            chk("abort_rvalid", host_rvalid, 0);
`ifdef KERNEL_CYCLE_COUNT_EN
            chk("abort_run_cycles", run_cycles, 0);
`endif
            for (int i = 0; i < 3; i++) begin
               chk("abort_done", done, 0);
               chk("abort_idle_busy", busy, 0);
               tick;
            end
            return;
         end
      end
      // DONE: run is ignored, kernel writes must not reach the RAM, host reads addr 12.
      run = 1; host_req = 1; host_we = 0; host_addr = 12;
      kern_w_enable = 0; kern_we = 1; kern_addr = 12; kern_wdata = {$urandom, $urandom};
      #1;
      chk("d_done", done, 1);
      chk("d_busy", busy, 0);
      chk("d_r_enable", kern_r_enable, 0);
      chk("d_host_gnt", host_gnt, 1);
      chk("d_mem_we", mem_we, 0);
      chk("d_mem_addr", mem_addr, 12);
`ifdef KERNEL_CYCLE_COUNT_EN
      chk("d_run_cycles", run_cycles, lat + 1);
`endif
      busy_n += int'(busy); kre_n += int'(kern_r_enable); done_n += int'(done);
      tick;
      run = 0; host_req = 0; kern_we = 0;
      #1;
      chk("i_done", done, 0);
      chk("i_busy", busy, 0);
      chk("i_r_enable", kern_r_enable, 0);
      chk("i_rvalid", host_rvalid, 1);
      chk("i_rdata12", host_rdata, exp_mem[12]);
      chk("i_rdata12_neg4", host_rdata, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("busy_cycles", busy_n, lat + 1);
      chk("r_enable_cycles", kre_n, 1);
      chk("done_pulses", done_n, 1);
      for (int i = 0; i < 2; i++) begin
         tick;
         chk("i_host_gnt_idle", host_gnt, host_req);
`ifdef KERNEL_CYCLE_COUNT_EN
         chk("i_run_cycles_held", run_cycles, lat + 1);
`endif
      end
      tick;
   endtask

   initial begin
      rst = 1;
      tick; tick;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_r_enable", kern_r_enable, 0);
      chk("rst_rvalid", host_rvalid, 0);
      rst = 0;
      host_req = 1;
      #1;
      chk("rst_host_owner", host_gnt, 1);
      host_req = 0;
      tick;
`ifdef KERNEL_CYCLE_COUNT_EN
      chk("rst_run_cycles", run_cycles, 0);
`endif
      for (int a = 0; a < 1000; a++) begin
         host_req = 1; host_we = 1; host_addr = 10'(a); host_wdata = 64'(a * 3);
         #1;
         chk("wr_gnt", host_gnt, 1);
         chk("wr_mem_we", mem_we, 1);
         exp_mem[a] = 64'(a * 3);
         tick;
      end
      host_we = 0; host_addr = 5;
      #1;
      chk("rd5_gnt", host_gnt, 1);
      tick;
      host_req = 0;
      #1;
      chk("rd5_rvalid", host_rvalid, 1);
      chk("rd5_rdata", host_rdata, 15);
      tick;
      chk("rd5_rvalid_drop", host_rvalid, 0);
      host_random(300);
      run_kernel(7, 0, 0);
      run_kernel(4, 1, 0);
      run_kernel(6, 0, 3);
      run_kernel(5, 0, 0);
      host_random(100);
      run_kernel(100, 0, 0);
      run_kernel(1, 1, 0);
      host_random(50);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
